// File: rtl/arduino_adc_onchip_memory_dp_if.sv
// Avalon-MM slave bus bundle for one port of the dual-port on-chip RAM.
//   address        word address
//   chipselect     port select
//   read / write   transfer requests; write wins when both are high
//   byteenable     byte-lane write mask
//   writedata      write data
//   readdata       read data, meaningful while readdatavalid is high, held otherwise
//   readdatavalid  one pulse per accepted read
// master: the requester (Nios data master, ADC DMA, bench). slave: the RAM.
interface arduino_adc_onchip_memory_dp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/arduino_adc_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports.
// s1 serves the Nios data master, s2 the ADC sample DMA. Reads are pipelined
// (READ_LATENCY 1 or 2) and never stall; writes use byte-lane masks.
// Ports:
//   clk        single clock
//   reset      synchronous, active-high; clears the read pipeline, not the memory
//   clken      global clock enable
//   reset_req  stall request; the effective enable is clken & ~reset_req
//   s1, s2     Avalon-MM slave ports (see arduino_adc_onchip_memory_dp_if)
// Collisions at one address in one cycle: s1 wins byte lanes both ports write;
// a read on one port while the other writes returns the old word.
module arduino_adc_onchip_memory_dp #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "arduino_adc_onchip_memory2.hex"
) (
    input logic                           clk,
    input logic                           reset,
    input logic                           clken,
    input logic                           reset_req,
    arduino_adc_onchip_memory_dp_if.slave s1,
    arduino_adc_onchip_memory_dp_if.slave s2
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic en;
    logic s1_wr, s1_rd;
    logic s2_wr, s2_rd;

    assign en    = clken & ~reset_req;
    assign s1_wr = en & s1.chipselect & s1.write;
    assign s1_rd = en & s1.chipselect & s1.read & ~s1.write;
    assign s2_wr = en & s2.chipselect & s2.write;
    assign s2_rd = en & s2.chipselect & s2.read & ~s2.write;

    // Both write ports live in one process. s1 is assigned last so its lanes
    // override s2 on a same-address collision; s2-only lanes still land.
    always_ff @(posedge clk) begin : mem_write
        for (int b = 0; b < NUM_LANES; b++) begin
            if (s2_wr && s2.byteenable[b]) begin
                mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
            end
            if (s1_wr && s1.byteenable[b]) begin
                mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
            end
        end
    end

    // First read stage: memory sampled at the accept edge, so a concurrent
    // write on either port is not yet visible (old data).
    logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
    logic                  s1_vld_q, s2_vld_q;

    always_ff @(posedge clk) begin : read_stage1
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
        end else if (en) begin
            s1_vld_q <= s1_rd;
            s2_vld_q <= s2_rd;
            if (s1_rd) begin
                s1_data_q <= mem[s1.address];
            end
            if (s2_rd) begin
                s2_data_q <= mem[s2.address];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data2_q, s2_data2_q;
        logic                  s1_vld2_q, s2_vld2_q;

        // Data only moves with a valid beat so readdata holds between results.
        always_ff @(posedge clk) begin : read_stage2
            if (reset) begin
                s1_vld2_q  <= 1'b0;
                s1_data2_q <= '0;
                s2_vld2_q  <= 1'b0;
                s2_data2_q <= '0;
            end else if (en) begin
                s1_vld2_q <= s1_vld_q;
                s2_vld2_q <= s2_vld_q;
                if (s1_vld_q) begin
                    s1_data2_q <= s1_data_q;
                end
                if (s2_vld_q) begin
                    s2_data2_q <= s2_data_q;
                end
            end
        end

        assign s1.readdata      = s1_data2_q;
        assign s1.readdatavalid = s1_vld2_q;
        assign s2.readdata      = s2_data2_q;
        assign s2.readdatavalid = s2_vld2_q;
    end else begin : g_lat1
        assign s1.readdata      = s1_data_q;
        assign s1.readdatavalid = s1_vld_q;
        assign s2.readdata      = s2_data_q;
        assign s2.readdatavalid = s2_vld_q;
    end

endmodule
